// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache FSM encoding and derived address-field widths
package cache_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WRITEBACK = 2'd1;
   localparam logic [1:0] ST_FILL      = 2'd2;
   localparam logic [1:0] ST_RESPOND   = 2'd3;

   function automatic int byte_bits(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   function automatic int word_bits(input int block_words);
      return $clog2(block_words);
   endfunction

   function automatic int index_bits(input int num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int tag_bits(input int addr_width, input int data_width,
                                   input int block_words, input int num_sets);
      return addr_width - index_bits(num_sets) - word_bits(block_words) - byte_bits(data_width);
   endfunction

endpackage

// File: rtl/cache_lru_nway.sv
// rtl/cache_lru_nway.sv - per-set true-LRU age tracking; reports the oldest way of the indexed set
module cache_lru_nway
   import cache_pkg::*;
#(
   parameter int NUM_WAYS = 4,
   parameter int NUM_SETS = 16,
   localparam int WAY_BITS = $clog2(NUM_WAYS),
   localparam int SET_BITS = index_bits(NUM_SETS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SET_BITS-1:0] set_idx,
   input  logic [WAY_BITS-1:0] access_way,
   input  logic                access,
   output logic [WAY_BITS-1:0] victim_way
);

   logic [WAY_BITS-1:0] age [NUM_SETS][NUM_WAYS];

   // Ages remain a permutation: younger ways shift up by one, the touched way becomes 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++)
               age[s][w] <= WAY_BITS'(w);
      end else if (access) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (WAY_BITS'(w) == access_way)
               age[set_idx][w] <= '0;
            else if (age[set_idx][w] < age[set_idx][access_way])
               age[set_idx][w] <= age[set_idx][w] + WAY_BITS'(1);
         end
      end
   end

   always_comb begin
      victim_way = '0;
      for (int w = 0; w < NUM_WAYS; w++)
         if (age[set_idx][w] == WAY_BITS'(NUM_WAYS - 1))
            victim_way = WAY_BITS'(w);
   end

endmodule

// File: rtl/cache_nway.sv
// rtl/cache_nway.sv - N-way set-associative write-back cache with evict/fill FSM
module cache_nway
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_WAYS    = 4,
   parameter int NUM_SETS    = 16,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_hit,
   output logic                  mem_req_valid,
   output logic                  mem_req_write,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int BB = byte_bits(DATA_WIDTH);
   localparam int WB = word_bits(BLOCK_WORDS);
   localparam int IB = index_bits(NUM_SETS);
   localparam int TB = tag_bits(ADDR_WIDTH, DATA_WIDTH, BLOCK_WORDS, NUM_SETS);
   localparam int AB = $clog2(NUM_WAYS);

   logic [1:0]            state;
   logic [WB-1:0]         beat;
   logic [TB-1:0]         tag_mem  [NUM_SETS][NUM_WAYS];
   logic [DATA_WIDTH-1:0] data_mem [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
   logic [NUM_WAYS-1:0]   valid    [NUM_SETS];
   logic [NUM_WAYS-1:0]   dirty    [NUM_SETS];

   logic                  lat_write;
   logic [TB-1:0]         lat_tag;
   logic [IB-1:0]         lat_index;
   logic [WB-1:0]         lat_word;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic [AB-1:0]         lat_way;
   logic [TB-1:0]         victim_tag;

   logic [TB-1:0] req_tag;
   logic [IB-1:0] req_index;
   logic [WB-1:0] req_word;
   logic          accept, hit, has_inv, beat_last, lru_access;
   logic [AB-1:0] hit_way, inv_way, lru_victim, miss_way, lru_way;
   logic [IB-1:0] lru_index;
   logic          unused_byte_bits;

   assign req_tag          = req_addr[ADDR_WIDTH-1 -: TB];
   assign req_index        = req_addr[BB+WB +: IB];
   assign req_word         = req_addr[BB +: WB];
   assign unused_byte_bits = ^req_addr[BB-1:0];

   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign beat_last = (beat == WB'(BLOCK_WORDS - 1));

   // Lowest invalid way wins over the LRU choice, hence the descending scan.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      has_inv = 1'b0;
      inv_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid[req_index][w] && tag_mem[req_index][w] == req_tag) begin
            hit     = 1'b1;
            hit_way = AB'(w);
         end
      end
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid[req_index][w]) begin
            has_inv = 1'b1;
            inv_way = AB'(w);
         end
      end
   end

   assign miss_way   = has_inv ? inv_way : lru_victim;
   assign lru_index  = (state == ST_RESPOND) ? lat_index : req_index;
   assign lru_way    = (state == ST_RESPOND) ? lat_way : hit_way;
   assign lru_access = (accept && hit) || (state == ST_RESPOND);

   cache_lru_nway #(
      .NUM_WAYS (NUM_WAYS),
      .NUM_SETS (NUM_SETS)
   ) u_lru (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_idx    (lru_index),
      .access_way (lru_way),
      .access     (lru_access),
      .victim_way (lru_victim)
   );

   // Beat signals are decoded from held state so they stay stable until mem_ack.
   assign mem_req_valid = (state == ST_WRITEBACK) || (state == ST_FILL);
   assign mem_req_write = (state == ST_WRITEBACK);
   assign mem_req_addr  = mem_req_valid
                        ? {(mem_req_write ? victim_tag : lat_tag), lat_index, beat, {BB{1'b0}}}
                        : '0;
   assign mem_wdata     = mem_req_write ? data_mem[lat_index][lat_way][beat] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         beat       <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_hit   <= 1'b0;
         lat_write  <= 1'b0;
         lat_tag    <= '0;
         lat_index  <= '0;
         lat_word   <= '0;
         lat_wdata  <= '0;
         lat_way    <= '0;
         victim_tag <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid[s] <= '0;
            dirty[s] <= '0;
         end
      end else begin
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept && hit) begin
                  resp_valid <= 1'b1;
                  resp_hit   <= 1'b1;
                  resp_rdata <= req_write ? req_wdata : data_mem[req_index][hit_way][req_word];
                  if (req_write)
                     dirty[req_index][hit_way] <= 1'b1;
               end else if (accept) begin
                  lat_write  <= req_write;
                  lat_tag    <= req_tag;
                  lat_index  <= req_index;
                  lat_word   <= req_word;
                  lat_wdata  <= req_wdata;
                  lat_way    <= miss_way;
                  victim_tag <= tag_mem[req_index][miss_way];
                  beat       <= '0;
                  // Line is invalid while it is being replaced, so an abort leaves nothing half-valid.
                  valid[req_index][miss_way] <= 1'b0;
                  state <= (valid[req_index][miss_way] && dirty[req_index][miss_way])
                         ? ST_WRITEBACK : ST_FILL;
               end
            end
            ST_WRITEBACK: begin
               if (mem_ack) begin
                  beat <= beat_last ? '0 : beat + WB'(1);
                  if (beat_last)
                     state <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (mem_ack) begin
                  beat <= beat_last ? '0 : beat + WB'(1);
                  if (beat_last) begin
                     valid[lat_index][lat_way] <= 1'b1;
                     dirty[lat_index][lat_way] <= 1'b0;
                     state <= ST_RESPOND;
                  end
               end
            end
            ST_RESPOND: begin
               resp_valid <= 1'b1;
               resp_hit   <= 1'b0;
               resp_rdata <= lat_write ? lat_wdata : data_mem[lat_index][lat_way][lat_word];
               if (lat_write)
                  dirty[lat_index][lat_way] <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_IDLE && accept && hit && req_write)
         data_mem[req_index][hit_way][req_word] <= req_wdata;
      if (state == ST_FILL && mem_ack) begin
         data_mem[lat_index][lat_way][beat] <= mem_rdata;
         if (beat_last)
            tag_mem[lat_index][lat_way] <= lat_tag;
      end
      if (state == ST_RESPOND && lat_write)
         data_mem[lat_index][lat_way][lat_word] <= lat_wdata;
   end

endmodule

// File: tb/tb_cache_nway.sv
// tb/tb_cache_nway.sv - directed and random checks of cache_nway against an LRU-list cache model
module tb_cache_nway;

   localparam int NW = 4;

   typedef struct packed {
      logic        w;
      logic [15:0] a;
      logic [31:0] d;
   } beat_t;

   typedef struct packed {
      logic [7:0]       tag;
      logic             dirty;
      logic [3:0][31:0] data;
   } line_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid, resp_hit;
   logic [31:0] resp_rdata;
   logic        mem_req_valid, mem_req_write, mem_ack;
   logic [15:0] mem_req_addr;
   logic [31:0] mem_wdata, mem_rdata;

   int tests_run = 0;
   int fails     = 0;

   // Model: each set is a recency-ordered list of resident lines, most recent first.
   line_t       sets [16][$];
   logic [31:0] mem [logic [15:0]];
   beat_t       beat_log [$];
   int          acks_given = 0;
   int          ack_limit  = 1000000;
   bit          ack_rand   = 1'b1;

   cache_nway dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .resp_hit      (resp_hit),
      .mem_req_valid (mem_req_valid),
      .mem_req_write (mem_req_write),
      .mem_req_addr  (mem_req_addr),
      .mem_wdata     (mem_wdata),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_rd(input logic [15:0] a);
      return mem.exists(a) ? mem[a] : (32'h5000_0000 | {16'h0, a});
   endfunction

   // Backing memory: acks (randomly delayed) at the falling edge, consumed at the next rising edge.
   always @(negedge clk) begin
      beat_t bt;
      if (rst_n && mem_req_valid && acks_given < ack_limit &&
          (!ack_rand || $urandom_range(0, 2) != 0)) begin
         mem_ack   = 1'b1;
         mem_rdata = mem_rd(mem_req_addr);
         if (mem_req_write)
            mem[mem_req_addr] = mem_wdata;
         bt.w = mem_req_write;
         bt.a = mem_req_addr;
         bt.d = mem_req_write ? mem_wdata : 32'h0;
         beat_log.push_back(bt);
         acks_given++;
      end else begin
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      for (int s = 0; s < 16; s++)
         sets[s].delete();
   endfunction

   function automatic void model_access(input bit wr, input logic [15:0] a, input logic [31:0] wd,
                                        output bit hit, output logic [31:0] rd, output beat_t ex[$]);
      logic [7:0] t;
      int         s;
      int         wi;
      int         p;
      line_t      ln;
      line_t      v;
      beat_t      bt;
      logic [3:0] s4;
      t  = a[15:8];
      s4 = a[7:4];
      s  = int'(s4);
      wi = int'(a[3:2]);
      p  = -1;
      ex.delete();
      for (int i = 0; i < sets[s].size(); i++)
         if (sets[s][i].tag == t)
            p = i;
      if (p >= 0) begin
         hit = 1'b1;
         ln  = sets[s][p];
         sets[s].delete(p);
      end else begin
         hit = 1'b0;
         if (sets[s].size() == NW) begin
            v = sets[s].pop_back();
            if (v.dirty)
               for (int b = 0; b < 4; b++) begin
                  bt.w = 1'b1;
                  bt.a = {v.tag, s4, 2'(b), 2'b00};
                  bt.d = v.data[b];
                  ex.push_back(bt);
               end
         end
         ln.tag   = t;
         ln.dirty = 1'b0;
         for (int b = 0; b < 4; b++) begin
            bt.w = 1'b0;
            bt.a = {t, s4, 2'(b), 2'b00};
            bt.d = 32'h0;
            ln.data[b] = mem_rd(bt.a);
            ex.push_back(bt);
         end
      end
      if (wr) begin
         ln.data[wi] = wd;
         ln.dirty    = 1'b1;
      end
      rd = wr ? wd : ln.data[wi];
      sets[s].push_front(ln);
   endfunction

   task automatic do_req(input bit wr, input logic [15:0] a, input logic [31:0] wd, input string nm);
      bit          eh;
      logic [31:0] er;
      beat_t       ex [$];
      int          cyc;
      bit          got;
      model_access(wr, a, wd, eh, er, ex);
      beat_log.delete();
      acks_given = 0;
      check({nm, "_ready"}, req_ready, 1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'b0;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1 && !eh)
            check({nm, "_ready_low"}, req_ready, 0);
         if (resp_valid)
            got = 1'b1;
      end
      check({nm, "_resp_seen"}, got, 1);
      if (got) begin
         check({nm, "_rdata"}, resp_rdata, er);
         check({nm, "_hit"}, resp_hit, eh);
         if (eh)
            check({nm, "_hit_latency"}, cyc, 1);
         check({nm, "_beats"}, beat_log.size(), ex.size());
         for (int i = 0; i < ex.size() && i < beat_log.size(); i++)
            check({nm, "_beat"}, beat_log[i], ex[i]);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
   endtask

   initial begin
      logic [15:0] b_addr [8];
      logic [31:0] b_exp  [8];
      logic [7:0]  b_tag  [4];
      logic [15:0] ra;
      bit          bh;
      beat_t       bq [$];
      int          cyc;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      for (int b = 0; b < 4; b++)
         mem[16'h0120 + 16'(4 * b)] = 32'hA0 + 32'(b);

      repeat (2) @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_resp_hit", resp_hit, 0);
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_mem_req_write", mem_req_write, 0);
      check("rst_mem_req_addr", mem_req_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      rst_n = 1'b1;
      model_clear();
      @(negedge clk);

      do_req(1'b0, 16'h0120, 32'h0, "cold_read");
      do_req(1'b0, 16'h0124, 32'h0, "hit_read");
      do_req(1'b1, 16'h0128, 32'hDEADBEEF, "write_hit");
      do_req(1'b0, 16'h0128, 32'h0, "read_after_write");

      do_req(1'b0, 16'h0220, 32'h0, "fill_t2");
      do_req(1'b0, 16'h0320, 32'h0, "fill_t3");
      do_req(1'b0, 16'h0420, 32'h0, "fill_t4");
      do_req(1'b0, 16'h0120, 32'h0, "touch_t1");
      do_req(1'b0, 16'h0520, 32'h0, "evict_clean_t2");
      do_req(1'b0, 16'h0220, 32'h0, "reread_t2_miss");

      do_req(1'b0, 16'h0424, 32'h0, "age_t4");
      do_req(1'b0, 16'h0528, 32'h0, "age_t5");
      do_req(1'b0, 16'h022C, 32'h0, "age_t2");
      do_req(1'b0, 16'h0620, 32'h0, "evict_dirty_t1");

      b_tag[0] = 8'h06;
      b_tag[1] = 8'h02;
      b_tag[2] = 8'h05;
      b_tag[3] = 8'h04;
      for (int i = 0; i < 8; i++) begin
         b_addr[i] = {b_tag[i % 4], 4'h2, 2'((i * 3) % 4), 2'b00};
         model_access(1'b0, b_addr[i], 32'h0, bh, b_exp[i], bq);
         check("b2b_model_hit", bh, 1);
      end
      beat_log.delete();
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin
            check("b2b_resp_valid", resp_valid, 1);
            check("b2b_rdata", resp_rdata, b_exp[i-1]);
            check("b2b_hit", resp_hit, 1);
         end
         check("b2b_ready", req_ready, 1);
         if (i < 8) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = b_addr[i];
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("b2b_no_mem", beat_log.size(), 0);

      for (int n = 0; n < 60; n++) begin
         ra = {8'($urandom_range(1, 6)), 4'($urandom_range(2, 3)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         do_req(1'($urandom_range(0, 1)), ra, $urandom, "rnd");
      end

      apply_reset();
      ack_rand   = 1'b0;
      ack_limit  = 2;
      beat_log.delete();
      acks_given = 0;
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_addr   = 16'h0120;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      cyc = 0;
      while (beat_log.size() < 2 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("midfill_two_beats", beat_log.size(), 2);
      @(negedge clk);
      check("midfill_busy", mem_req_valid, 1);
      rst_n = 1'b0;
      #1;
      check("midfill_mem_drop", mem_req_valid, 0);
      check("midfill_resp_none", resp_valid, 0);
      check("midfill_ready", req_ready, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midfill_resp_quiet", resp_valid, 0);
      end
      rst_n = 1'b1;
      model_clear();
      ack_limit = 1000000;
      ack_rand  = 1'b1;
      @(negedge clk);
      check("midfill_resp_after", resp_valid, 0);
      do_req(1'b0, 16'h0120, 32'h0, "midfill_reread");

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
